// File: rtl/channel_sequencer_pkg.sv
// Shared types and constants for the channel sequencer.
package channel_sequencer_pkg;

  localparam int unsigned CHAN_W = 3;

  localparam logic [CHAN_W-1:0] CHAN_BLANK = 3'b111;

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_AUTO   = 2'd1,
    ST_BLANK  = 2'd2
  } state_e;

endpackage

// File: rtl/channel_sequencer_button_debouncer.sv
// Raw pushbutton -> synchronized, debounced, single-cycle press pulse.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_btn,
  output logic o_press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       r_sync;
  logic [1:0]       r_fill;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_level_d;
  logic             r_armed;
  logic             r_press;

  logic w_sample;
  logic w_differs;
  logic w_accept;

  assign w_sample  = r_sync[1];
  assign w_differs = (w_sample != r_level);
  assign w_accept  = w_differs && (r_cnt == CNT_LAST);

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk) begin
    if (!resetn) r_sync <= '0;
    else         r_sync <= {r_sync[0], i_btn};
  end

  // Marks when the synchronizer holds real samples rather than reset zeros.
  always_ff @(posedge clk) begin
    if (!resetn) r_fill <= '0;
    else         r_fill <= {r_fill[0], 1'b1};
  end

  // Count consecutive samples that disagree with the accepted level.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (!w_differs) begin
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_level <= w_sample;
    end else begin
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  // A button held through reset must be seen released before it may press.
  always_ff @(posedge clk) begin
    if (!resetn) r_armed <= 1'b0;
    else         r_armed <= r_armed | (r_fill[1] & ~w_sample);
  end

  // Rising edge of the debounced level becomes a one-cycle press.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
    end else begin
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d & r_armed;
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/channel_sequencer.sv
// Channel selector with manual/auto stepping, blanking and debounced buttons.
module channel_sequencer
  import channel_sequencer_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS    = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned AUTO_PERIOD     = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              btn_next,
  input  logic              btn_mode,
  input  logic              enable,
  input  logic              tick,
  output logic [CHAN_W-1:0] curr_channel,
  output logic              auto_mode,
  output logic              chan_changed
);

  localparam int unsigned TICK_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(AUTO_PERIOD - 1);
  localparam logic [CHAN_W-1:0] IDX_LAST  = CHAN_W'(NUM_CHANNELS - 1);

  state_e            r_state;
  state_e            r_ret_mode;
  logic [CHAN_W-1:0] r_index;
  logic [TICK_W-1:0] r_tick_cnt;
  logic [CHAN_W-1:0] r_curr;
  logic              r_auto;
  logic              r_changed;

  state_e            w_state_nxt;
  state_e            w_ret_nxt;
  logic [CHAN_W-1:0] w_index_nxt;
  logic [TICK_W-1:0] w_tick_nxt;
  logic              w_advance;
  logic              w_press_next;
  logic              w_press_mode;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_dbn_next (
    .clk     (clk),
    .resetn  (resetn),
    .i_btn   (btn_next),
    .o_press (w_press_next)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_dbn_mode (
    .clk     (clk),
    .resetn  (resetn),
    .i_btn   (btn_mode),
    .o_press (w_press_mode)
  );

  // State and retained-mode registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= ST_MANUAL;
      r_ret_mode <= ST_MANUAL;
    end else begin
      r_state    <= w_state_nxt;
      r_ret_mode <= w_ret_nxt;
    end
  end

  // Next state, tick counter and advance decision; mode press beats next press.
  always_comb begin
    w_state_nxt = r_state;
    w_ret_nxt   = r_ret_mode;
    w_tick_nxt  = r_tick_cnt;
    w_advance   = 1'b0;
    case (r_state)
      ST_MANUAL: begin
        if (!enable) begin
          w_state_nxt = ST_BLANK;
          w_ret_nxt   = ST_MANUAL;
        end else if (w_press_mode) begin
          w_state_nxt = ST_AUTO;
          w_tick_nxt  = '0;
        end else if (w_press_next) begin
          w_advance   = 1'b1;
        end
      end
      ST_AUTO: begin
        if (!enable) begin
          w_state_nxt = ST_BLANK;
          w_ret_nxt   = ST_AUTO;
        end else if (w_press_mode) begin
          w_state_nxt = ST_MANUAL;
          w_tick_nxt  = '0;
        end else if (w_press_next) begin
          w_advance   = 1'b1;
          w_tick_nxt  = '0;
        end else if (tick) begin
          if (r_tick_cnt == TICK_LAST) begin
            w_advance  = 1'b1;
            w_tick_nxt = '0;
          end else begin
            w_tick_nxt = r_tick_cnt + TICK_W'(1);
          end
        end
      end
      ST_BLANK: begin
        if (enable) begin
          w_state_nxt = r_ret_mode;
          w_tick_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = ST_MANUAL;
      end
    endcase
    w_index_nxt = r_index;
    if (w_advance) begin
      w_index_nxt = (r_index == IDX_LAST) ? '0 : r_index + CHAN_W'(1);
    end
  end

  // Index, tick counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_index    <= '0;
      r_tick_cnt <= '0;
      r_curr     <= '0;
      r_auto     <= 1'b0;
      r_changed  <= 1'b0;
    end else begin
      r_index    <= w_index_nxt;
      r_tick_cnt <= w_tick_nxt;
      r_curr     <= (w_state_nxt == ST_BLANK) ? CHAN_BLANK : w_index_nxt;
      r_auto     <= (w_state_nxt == ST_AUTO);
      r_changed  <= (w_index_nxt != r_index);
    end
  end

  assign curr_channel = r_curr;
  assign auto_mode    = r_auto;
  assign chan_changed = r_changed;

endmodule

// File: tb/tb_channel_sequencer.sv
// Directed plus randomized bench with a rule-level reference model.
module tb_channel_sequencer;

  localparam int unsigned NCH = 3;
  localparam int unsigned DB  = 4;
  localparam int unsigned AP  = 3;

  logic       clk = 1'b0;
  logic       resetn;
  logic       btn_next;
  logic       btn_mode;
  logic       enable;
  logic       tick;
  logic [2:0] curr_channel;
  logic       auto_mode;
  logic       chan_changed;

  int n_cmp   = 0;
  int n_err   = 0;
  int obs_chg = 0;

  // Reference model state: per button (0 = next, 1 = mode).
  bit          m_s1    [2];
  bit          m_s2    [2];
  bit          m_lvl   [2];
  bit          m_lvl_d [2];
  bit          m_arm   [2];
  bit          m_press [2];
  bit [DB-1:0] m_hist  [2];
  int          m_hcnt  [2];
  int          m_fill;
  bit          m_blank;
  bit          m_auto;
  int          m_idx;
  int          m_ticks;
  logic [2:0]  e_curr;
  logic        e_auto;
  logic        e_chg;

  always #5 clk = ~clk;

  channel_sequencer #(
    .NUM_CHANNELS    (NCH),
    .DEBOUNCE_CYCLES (DB),
    .AUTO_PERIOD     (AP)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .btn_next     (btn_next),
    .btn_mode     (btn_mode),
    .enable       (enable),
    .tick         (tick),
    .curr_channel (curr_channel),
    .auto_mode    (auto_mode),
    .chan_changed (chan_changed)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    bit raw [2];
    bit pn, pm, adv, smp, stable;
    int prev_idx;
    raw[0] = btn_next;
    raw[1] = btn_mode;
    if (!resetn) begin
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_lvl_d[b] = 0;
        m_arm[b] = 0; m_press[b] = 0; m_hist[b] = '0; m_hcnt[b] = 0;
      end
      m_fill = 0; m_blank = 0; m_auto = 0; m_idx = 0; m_ticks = 0;
      e_curr = 3'b000; e_auto = 1'b0; e_chg = 1'b0;
      return;
    end
    pn = m_press[0];
    pm = m_press[1];
    prev_idx = m_idx;
    adv = 0;
    if (m_blank) begin
      if (enable) begin
        m_blank = 0;
        m_ticks = 0;
      end
    end else if (!enable) begin
      m_blank = 1;
    end else if (pm) begin
      m_auto  = !m_auto;
      m_ticks = 0;
    end else if (pn) begin
      adv     = 1;
      m_ticks = 0;
    end else if (m_auto && tick) begin
      m_ticks++;
      if (m_ticks == AP) begin
        m_ticks = 0;
        adv     = 1;
      end
    end
    if (adv) m_idx = (m_idx + 1) % NCH;
    for (int b = 0; b < 2; b++) begin
      smp = m_s2[b];
      m_press[b] = m_lvl[b] & ~m_lvl_d[b] & m_arm[b];
      m_lvl_d[b] = m_lvl[b];
      if (m_fill >= 2 && !smp) m_arm[b] = 1;
      m_hist[b] = {m_hist[b][DB-2:0], smp};
      if (m_hcnt[b] < DB) m_hcnt[b]++;
      stable = (m_hcnt[b] >= DB) && (m_hist[b] == {DB{smp}});
      if (stable) m_lvl[b] = smp;
      m_s2[b] = m_s1[b];
      m_s1[b] = raw[b];
    end
    if (m_fill < 2) m_fill++;
    e_curr = m_blank ? 3'b111 : 3'(m_idx);
    e_auto = m_auto && !m_blank;
    e_chg  = (m_idx != prev_idx);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    if (chan_changed === 1'b1) obs_chg++;
    check("curr_channel", 32'(curr_channel), 32'(e_curr));
    check("auto_mode", 32'(auto_mode), 32'(e_auto));
    check("chan_changed", 32'(chan_changed), 32'(e_chg));
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic press(input int which, input int hold, input int gap);
    if (which == 0) btn_next = 1'b1; else btn_mode = 1'b1;
    run(hold);
    if (which == 0) btn_next = 1'b0; else btn_mode = 1'b0;
    run(gap);
  endtask

  task automatic one_tick();
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    cycle();
  endtask

  initial begin
    int c0;
    int waited;
    resetn = 1'b0; btn_next = 1'b0; btn_mode = 1'b0; enable = 1'b1; tick = 1'b0;
    run(3);
    check("reset_curr", 32'(curr_channel), 32'd0);
    check("reset_auto", 32'(auto_mode), 32'd0);
    resetn = 1'b1;
    run(3);

    // Three clean presses: 1, 2, 0 with one pulse each.
    for (int i = 0; i < 3; i++) begin
      c0 = obs_chg;
      press(0, 6, 10);
      check("press_seq", 32'(curr_channel), 32'((i + 1) % 3));
      check("press_pulses", 32'(obs_chg - c0), 32'd1);
    end

    // Short glitch ignored; long hold gives one advance.
    c0 = obs_chg;
    press(0, 2, 10);
    check("glitch_curr", 32'(curr_channel), 32'd0);
    check("glitch_pulses", 32'(obs_chg - c0), 32'd0);
    c0 = obs_chg;
    press(0, 10, 12);
    check("hold_curr", 32'(curr_channel), 32'd1);
    check("hold_pulses", 32'(obs_chg - c0), 32'd1);

    // Fresh start, enter AUTO, six ticks.
    resetn = 1'b0; run(2); resetn = 1'b1; run(3);
    press(1, 6, 10);
    check("auto_on", 32'(auto_mode), 32'd1);
    check("auto_start", 32'(curr_channel), 32'd0);
    for (int i = 0; i < 6; i++) begin
      one_tick();
      if (i == 1) check("auto_tick2", 32'(curr_channel), 32'd0);
      if (i == 2) check("auto_tick3", 32'(curr_channel), 32'd1);
      if (i == 5) check("auto_tick6", 32'(curr_channel), 32'd2);
    end

    // Next press coincident with the third tick: one advance, counter restarts.
    one_tick();
    one_tick();
    btn_next = 1'b1;
    waited = 0;
    while (!m_press[0] && waited < 20) begin
      cycle();
      waited++;
    end
    check("press_wait", 32'(waited < 20), 32'd1);
    c0 = obs_chg;
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    check("coinc_curr", 32'(curr_channel), 32'd0);
    check("coinc_pulses", 32'(obs_chg - c0), 32'd1);
    btn_next = 1'b0;
    run(10);
    for (int i = 0; i < 3; i++) begin
      one_tick();
      if (i == 1) check("restart_tick2", 32'(curr_channel), 32'd0);
      if (i == 2) check("restart_tick3", 32'(curr_channel), 32'd1);
    end

    // Blanking at channel 2.
    press(0, 6, 10);
    check("pre_blank", 32'(curr_channel), 32'd2);
    enable = 1'b0;
    cycle();
    check("blank_curr", 32'(curr_channel), 32'h7);
    check("blank_chg", 32'(chan_changed), 32'd0);
    press(0, 6, 10);
    for (int i = 0; i < 4; i++) one_tick();
    check("blank_hold", 32'(curr_channel), 32'h7);
    enable = 1'b1;
    cycle();
    check("unblank_curr", 32'(curr_channel), 32'd2);
    check("unblank_auto", 32'(auto_mode), 32'd1);
    check("unblank_chg", 32'(chan_changed), 32'd0);

    // Reset mid-AUTO with btn_next held through reset release.
    btn_next = 1'b1;
    run(3);
    resetn = 1'b0;
    run(2);
    check("rst_curr", 32'(curr_channel), 32'd0);
    check("rst_auto", 32'(auto_mode), 32'd0);
    resetn = 1'b1;
    c0 = obs_chg;
    run(20);
    check("held_no_adv", 32'(curr_channel), 32'd0);
    check("held_pulses", 32'(obs_chg - c0), 32'd0);
    btn_next = 1'b0;
    run(10);
    press(0, 6, 10);
    check("repress_curr", 32'(curr_channel), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0)   btn_next = ~btn_next;
      if ($urandom_range(0, 19) == 0)  btn_mode = ~btn_mode;
      if ($urandom_range(0, 39) == 0)  enable   = ~enable;
      tick   = ($urandom_range(0, 2) == 0);
      resetn = ($urandom_range(0, 249) != 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/channel_sequencer.md
CHANNEL_SEQUENCER -- requirements
Module: channel_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_CHANNELS, default 3, the number of selectable channels (2..7).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, the stable-input clock cycles required to accept a button level.
REQ-003 The block SHALL have parameter AUTO_PERIOD, default 8, the tick strobes per automatic channel advance (>=1).
REQ-004 clk  input  1  system clock; all logic rising-edge.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 btn_next  input  1  raw asynchronous pushbutton, active-high, requests the next channel.
REQ-007 btn_mode  input  1  raw asynchronous pushbutton, active-high, toggles manual/auto mode.
REQ-008 enable  input  1  synchronous; low blanks the output channel.
REQ-009 tick  input  1  single-cycle timing strobe, e.g. frame or beat.
REQ-010 curr_channel  output  3  selected channel code to the LED/display path; 3'b111 = blank.
REQ-011 auto_mode  output  1  high while in AUTO state.
REQ-012 chan_changed  output  1  single-cycle pulse on every change of the internal channel index.

Function
REQ-013 Each button SHALL pass a 2-flop synchronizer, then a debouncer that accepts a new level only after DEBOUNCE_CYCLES consecutive identical samples.
REQ-014 A "press" SHALL be a single-cycle pulse on the debounced 0->1 transition only; release and held levels produce no pulse.
REQ-015 FSM states SHALL be MANUAL, AUTO and BLANK.
REQ-016 MANUAL: a next-press advances the index by one; a mode-press moves to AUTO.
REQ-017 AUTO: a tick counter increments on each tick; on reaching AUTO_PERIOD it clears and advances the index; a mode-press moves to MANUAL and clears the tick counter.
REQ-018 AUTO: a next-press advances the index immediately and clears the tick counter.
REQ-019 Index advance SHALL wrap from NUM_CHANNELS-1 to 0.
REQ-020 A next-press and a tick-counter expiry in the same cycle SHALL produce exactly one advance.
REQ-021 A mode-press and a next-press in the same cycle: the mode toggle SHALL apply and the next-press SHALL be discarded.
REQ-022 enable low from any state SHALL enter BLANK the following cycle, with the prior mode retained in a register; presses and ticks are ignored in BLANK.
REQ-023 enable high in BLANK SHALL return to the retained mode with the index unchanged and the tick counter cleared.
REQ-024 curr_channel SHALL be registered: equal to the index in MANUAL/AUTO and 3'b111 in BLANK, updating one cycle after the causing event.
REQ-025 chan_changed SHALL assert in the same cycle curr_channel shows a new index; it does not assert on BLANK entry or exit.
REQ-026 Latency from a debounced edge to the curr_channel update SHALL be 2 cycles (press pulse, then register).

Reset
REQ-027 While resetn is low at a clock edge: state = MANUAL, retained mode = MANUAL, index = 0, curr_channel = 3'b000, auto_mode = 0, chan_changed = 0, tick counter = 0.
REQ-028 Reset SHALL clear synchronizer, debounce counters and debounced levels to 0, so a button held through reset release yields no press until it is released and pressed again.
REQ-029 Reset asserted mid-debounce or mid-AUTO-period SHALL discard all partial counts.

Structure
REQ-030 A shared package SHALL hold the state enum, CHAN_BLANK = 3'b111 and the channel-code width (3).
REQ-031 The synchronizer, debounce counter and edge detect SHALL form one sub-module, button_debouncer, instantiated once per button.
REQ-032 The counter widths SHALL be derived from the parameters with clog2.

Verification (DEBOUNCE_CYCLES=4, AUTO_PERIOD=3, NUM_CHANNELS=3)
REQ-033 Three clean btn_next presses from reset -> curr_channel 1, 2, 0, with one chan_changed pulse each.
REQ-034 btn_next glitch high for 2 cycles -> no change; held for 10 cycles -> exactly one advance.
REQ-035 btn_mode press, then 6 ticks -> auto_mode=1, curr_channel 0->1->2 after ticks 3 and 6.
REQ-036 In AUTO, next-press in the same cycle as the 3rd tick -> single advance and the tick counter restarts at 0.
REQ-037 enable low at channel 2 -> curr_channel=3'b111 with no chan_changed; presses ignored; enable high -> curr_channel=2 and mode restored.
REQ-038 resetn low during AUTO with btn_next held -> outputs at reset values; no advance after release until btn_next is released and pressed again.
